// File: rtl/tetris_pkg.sv
// Command/state encoding shared between the tetris engine and its input front-end.
package tetris_pkg;

    typedef enum logic [3:0] {
        NONE,
        INIT,
        WAIT,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        ROTATE,
        ROTATE_REV,
        HOLD,
        CLEAR,
        END
    } state_type;

endpackage

// File: rtl/tetris_input_ctrl.sv
// Button sync/debounce, auto-repeat, gravity ticks and single-cycle command
// arbitration in front of the tetris engine.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [24:0] REPEAT_DELAY    = 25'd25_000_000,
    parameter logic [24:0] REPEAT_PERIOD   = 25'd5_000_000,
    parameter logic [26:0] GRAVITY_CYCLES  = 27'd100_000_000,
    parameter logic [26:0] GRAVITY_STEP    = 27'd9_000_000,
    parameter logic [26:0] GRAVITY_MIN     = 27'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  btn,
    input  state_type   state,
    input  logic [15:0] score,
    output state_type   ctrl,
    output logic [3:0]  level
);

    logic [5:0]       sync1, sync2, deb, deb_prev;
    logic [5:0][19:0] deb_cnt;
    logic [2:0][24:0] hold_cnt;
    logic [2:0]       rep_fire;
    logic [26:0]      grav_cnt, grav_diff, period;
    logic [30:0]      step_total;
    logic             grav_run, grav_fire, accept, flush;
    logic [5:0]       pending, set_mask, issue_mask;
    state_type        prev_state, win;
    logic             score_unused;

    assign score_unused = ^{score[15:8], score[3:0]};

    // Product is kept wide so an out-of-range level cannot wrap before the compare.
    always_comb begin
        step_total = {27'd0, level} * {4'd0, GRAVITY_STEP};
        grav_diff  = '0;
        period     = GRAVITY_MIN;
        if (step_total < {4'd0, GRAVITY_CYCLES}) begin
            grav_diff = GRAVITY_CYCLES - step_total[26:0];
            if (grav_diff > GRAVITY_MIN) period = grav_diff;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) rep_fire[i] = deb[i] && (hold_cnt[i] == REPEAT_DELAY);
        grav_run  = (state != INIT) && (state != END);
        grav_fire = grav_run && (grav_cnt >= period - 27'd1);
        set_mask  = (deb & ~deb_prev) | {3'b000, rep_fire} | {3'b000, grav_fire, 2'b00};
        flush     = (state == INIT) && (prev_state == END);
        accept    = ((state == WAIT) || (state == INIT) || (state == END)) &&
                    (ctrl == NONE) && (|pending) && !flush;
    end

    always_comb begin
        win        = NONE;
        issue_mask = '0;
        if (accept) begin
            if (pending[3])      begin win = DROP;   issue_mask = 6'b001000; end
            else if (pending[5]) begin win = HOLD;   issue_mask = 6'b100000; end
            else if (pending[4]) begin win = ROTATE; issue_mask = 6'b010000; end
            else if (pending[0]) begin win = LEFT;   issue_mask = 6'b000001; end
            else if (pending[1]) begin win = RIGHT;  issue_mask = 6'b000010; end
            else                 begin win = DOWN;   issue_mask = 6'b000100; end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 20'd1;
                end
            end
        end
    end

    // After a repeat fires the count rewinds so it lands on REPEAT_DELAY again
    // one REPEAT_PERIOD later; this assumes REPEAT_PERIOD <= REPEAT_DELAY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!deb[i])          hold_cnt[i] <= '0;
                else if (rep_fire[i]) hold_cnt[i] <= REPEAT_DELAY - REPEAT_PERIOD + 25'd1;
                else                  hold_cnt[i] <= hold_cnt[i] + 25'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grav_cnt   <= '0;
            pending    <= '0;
            ctrl       <= NONE;
            level      <= '0;
            prev_state <= NONE;
        end else begin
            level      <= score[7:4];
            prev_state <= state;
            ctrl       <= win;
            if (!grav_run || win == DOWN || win == DROP || grav_fire) grav_cnt <= '0;
            else                                                      grav_cnt <= grav_cnt + 27'd1;
            // A set in the same edge as an issue of that bit keeps it pending.
            if (flush) pending <= '0;
            else       pending <= (pending & ~issue_mask) | set_mask;
        end
    end

endmodule
